// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the ALU operand sequencer and its load timer.
package alu_pkg;

   localparam int DATA_W = 8;

   localparam logic [2:0] OP_SUMA  = 3'b000;
   localparam logic [2:0] OP_RESTA = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_SHL_A = 3'b100;
   localparam logic [2:0] OP_SHR_A = 3'b101;
   localparam logic [2:0] OP_SHL_B = 3'b110;
   localparam logic [2:0] OP_SHR_B = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_B  = 3'd1,
      ST_LOAD_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_RESULT  = 3'd4
   } seq_state_e;

endpackage

// File: rtl/alu_load_timer.sv
// Idle counter for a partially loaded transaction; expire marks the cycle whose idle
// edge would bring the count to TIMEOUT_CYCLES.
module alu_load_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic idle_tick,
   output logic expire
);

   localparam logic [7:0] LAST_IDLE = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count_q, count_d;

   // Any cycle that is not an idle load cycle restarts the count.
   always_comb begin
      count_d = 8'd0;
      if (idle_tick) count_d = count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= 8'd0;
      else     count_q <= count_d;
   end

   assign expire = idle_tick && (count_q == LAST_IDLE);

endmodule

// File: rtl/alu_operand_sequencer.sv
// Byte-serial operand/opcode loader and result register for the 8-bit ALU.
// Optional partial-load abort is built when ALU_LOAD_TIMEOUT_EN is defined.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | waiting for operand A byte
//   ST_LOAD_B  | waiting for operand B byte
//   ST_LOAD_OP | waiting for opcode byte (low 3 bits used)
//   ST_EXEC    | datapath settles; result captured at end
//   ST_RESULT  | result_valid high until result_ready
module alu_operand_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_control,
   input  logic [DATA_W-1:0] alu_resultado,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              zero,
   output logic              timeout_err
);

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   seq_state_e        state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic              zero_q, zero_d;
   logic              accept;
   logic              load_expire;

   assign data_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD_B) || (state_q == ST_LOAD_OP);
   assign accept     = data_valid && data_ready;

`ifdef ALU_LOAD_TIMEOUT_EN
   logic idle_tick;
   logic timeout_err_q, timeout_err_d;

   assign idle_tick     = ((state_q == ST_LOAD_B) || (state_q == ST_LOAD_OP)) && !accept;
   assign timeout_err_d = load_expire;

   alu_load_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_load_timer (
      .clk       (clk),
      .rst       (rst),
      .idle_tick (idle_tick),
      .expire    (load_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) timeout_err_q <= 1'b0;
      else     timeout_err_q <= timeout_err_d;
   end

   assign timeout_err = timeout_err_q;
`else
   assign load_expire = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      ctrl_d   = ctrl_q;
      result_d = result_q;
      zero_d   = zero_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d     = data_in;
               state_d = ST_LOAD_B;
            end
         end
         ST_LOAD_B: begin
            if (accept) begin
               b_d     = data_in;
               state_d = ST_LOAD_OP;
            end else if (load_expire) begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD_OP: begin
            if (accept) begin
               ctrl_d  = data_in[2:0];
               state_d = ST_EXEC;
            end else if (load_expire) begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            result_d = alu_resultado;
            zero_d   = (alu_resultado == '0);
            state_d  = ST_RESULT;
         end
         ST_RESULT: begin
            if (result_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= OP_SUMA;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_control  = ctrl_q;
   assign result       = result_q;
   assign zero         = zero_q;
   assign result_valid = (state_q == ST_RESULT);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer driving a behavioural ALU datapath; timeout cases
// run only when ALU_LOAD_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 4).
module tb_alu_operand_sequencer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic [7:0] alu_a, alu_b, alu_resultado, result;
   logic [2:0] alu_control;
   logic       result_valid, result_ready, zero, timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_operand_sequencer #(.TIMEOUT_CYCLES(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_control   (alu_control),
      .alu_resultado (alu_resultado),
      .result        (result),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .zero          (zero),
      .timeout_err   (timeout_err)
   );

   // ALU datapath: adder, subtractor, logic, shifters and output mux.
   always_comb begin
      alu_resultado = 8'h00;
      case (alu_control)
         OP_SUMA:  alu_resultado = alu_a + alu_b;
         OP_RESTA: alu_resultado = alu_a - alu_b;
         OP_AND:   alu_resultado = alu_a & alu_b;
         OP_OR:    alu_resultado = alu_a | alu_b;
         OP_SHL_A: alu_resultado = alu_a << 1;
         OP_SHR_A: alu_resultado = alu_a >> 1;
         OP_SHL_B: alu_resultado = alu_b << 1;
         OP_SHR_B: alu_resultado = alu_b >> 1;
         default:  alu_resultado = 8'h00;
      endcase
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic [7:0] res;
      logic       z;
      logic [2:0] ctrl;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_alu_a"},       32'(alu_a), 32'h0);
      chk({tag, "_alu_b"},       32'(alu_b), 32'h0);
      chk({tag, "_alu_control"}, 32'(alu_control), 32'h0);
      chk({tag, "_result"},      32'(result), 32'h0);
      chk({tag, "_zero"},        32'(zero), 32'h0);
      chk({tag, "_result_valid"}, 32'(result_valid), 32'h0);
      chk({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
      chk({tag, "_data_ready"},  32'(data_ready), 32'h1);
   endtask

   // Presents three bytes back to back; returns at the negedge during EXEC.
   task automatic load_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      @(negedge clk); data_valid = 1'b1; data_in = a;
      @(negedge clk); data_in = b;
      @(negedge clk); data_in = op;
      @(negedge clk); data_valid = 1'b0; data_in = 8'h00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, tests %0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h05, 8'h03, 8'h00, 8'h08, 1'b0, OP_SUMA};
      vecs[1] = '{8'h0F, 8'hF0, 8'h02, 8'h00, 1'b1, OP_AND};
      vecs[2] = '{8'h0F, 8'hF0, 8'h03, 8'hFF, 1'b0, OP_OR};
      vecs[3] = '{8'h05, 8'h03, 8'hF9, 8'h02, 1'b0, OP_RESTA};
      vecs[4] = '{8'h81, 8'h03, 8'h04, 8'h02, 1'b0, OP_SHL_A};
      vecs[5] = '{8'h81, 8'h03, 8'h05, 8'h40, 1'b0, OP_SHR_A};
      vecs[6] = '{8'h10, 8'h81, 8'h06, 8'h02, 1'b0, OP_SHL_B};
      vecs[7] = '{8'h10, 8'h81, 8'h07, 8'h40, 1'b0, OP_SHR_B};
      vecs[8] = '{8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, OP_SUMA};
      vecs[9] = '{8'h00, 8'h01, 8'h01, 8'hFF, 1'b0, OP_RESTA};

      rst = 1'b1; data_in = 8'h00; data_valid = 1'b0; result_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("por");
      rst = 1'b0;

      foreach (vecs[i]) begin
         chk("idle_ready", 32'(data_ready), 32'h1);
         load_bytes(vecs[i].a, vecs[i].b, vecs[i].op);
         chk("exec_rv_low", 32'(result_valid), 32'h0);
         chk("exec_dready_low", 32'(data_ready), 32'h0);
         @(negedge clk);
         chk("res_valid", 32'(result_valid), 32'h1);
         chk("result", 32'(result), 32'(vecs[i].res));
         chk("zero", 32'(zero), 32'(vecs[i].z));
         chk("alu_control", 32'(alu_control), 32'(vecs[i].ctrl));
         chk("alu_a", 32'(alu_a), 32'(vecs[i].a));
         chk("alu_b", 32'(alu_b), 32'(vecs[i].b));
         result_ready = 1'b1;
         @(negedge clk);
         result_ready = 1'b0;
         chk("post_hs_rv", 32'(result_valid), 32'h0);
         chk("post_hs_result_held", 32'(result), 32'(vecs[i].res));
         chk("post_hs_ctrl_held", 32'(alu_control), 32'(vecs[i].ctrl));
      end

      // Result back-pressure with a waiting byte.
      load_bytes(8'h05, 8'h03, 8'h01);
      @(negedge clk);
      data_valid = 1'b1; data_in = 8'hAA;
      for (int i = 0; i < 10; i++) begin
         chk("hold_result", 32'(result), 32'h02);
         chk("hold_rv", 32'(result_valid), 32'h1);
         chk("hold_dready", 32'(data_ready), 32'h0);
         @(negedge clk);
      end
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk("hs_dready", 32'(data_ready), 32'h1);
      chk("hs_byte_not_taken", 32'(alu_a), 32'h05);
      chk("hs_rv_low", 32'(result_valid), 32'h0);
      @(negedge clk);
      chk("aa_as_next_a", 32'(alu_a), 32'hAA);
      data_in = 8'h01;
      @(negedge clk); data_in = 8'h00;
      @(negedge clk); data_valid = 1'b0;
      @(negedge clk);
      chk("aa_txn_result", 32'(result), 32'hAB);
      chk("aa_txn_rv", 32'(result_valid), 32'h1);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;

      // Reset while waiting for the opcode.
      @(negedge clk); data_valid = 1'b1; data_in = 8'h77;
      @(negedge clk); data_in = 8'h66;
      @(negedge clk); data_valid = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk_reset("rst_load_op");

      // Reset with a pending result.
      load_bytes(8'h0F, 8'hF0, 8'h03);
      @(negedge clk);
      chk("pre_rst_rv", 32'(result_valid), 32'h1);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk_reset("rst_result");
      @(negedge clk);
      chk("rst_no_delivery", 32'(result_valid), 32'h0);

`ifdef ALU_LOAD_TIMEOUT_EN
      begin
         int pulses;
         @(negedge clk); data_valid = 1'b1; data_in = 8'h11;
         @(negedge clk); data_valid = 1'b0;
         pulses = 0;
         for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (timeout_err) pulses++;
            if (i == 4) begin
               chk("to_pulse_cycle", 32'(timeout_err), 32'h1);
               chk("to_idle_ready", 32'(data_ready), 32'h1);
            end
         end
         chk("to_pulse_count", 32'(pulses), 32'h1);
         chk("to_a_kept", 32'(alu_a), 32'h11);
         load_bytes(8'h02, 8'h03, 8'h00);
         @(negedge clk);
         chk("to_restart_a", 32'(alu_a), 32'h02);
         chk("to_restart_result", 32'(result), 32'h05);
         result_ready = 1'b1;
         @(negedge clk);
         result_ready = 1'b0;

         @(negedge clk); data_valid = 1'b1; data_in = 8'h22;
         @(negedge clk); data_valid = 1'b0;
         pulses = 0;
         repeat (3) begin
            @(negedge clk);
            if (timeout_err) pulses++;
         end
         data_valid = 1'b1; data_in = 8'h33;
         @(negedge clk); data_in = 8'h00;
         if (timeout_err) pulses++;
         @(negedge clk); data_valid = 1'b0;
         if (timeout_err) pulses++;
         @(negedge clk);
         if (timeout_err) pulses++;
         chk("late_b_no_abort", 32'(pulses), 32'h0);
         chk("late_b_result", 32'(result), 32'h55);
         chk("late_b_rv", 32'(result_valid), 32'h1);
         result_ready = 1'b1;
         @(negedge clk);
         result_ready = 1'b0;
      end
`else
      @(negedge clk); data_valid = 1'b1; data_in = 8'h30;
      @(negedge clk); data_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("no_timeout_err", 32'(timeout_err), 32'h0);
      chk("no_timeout_ready", 32'(data_ready), 32'h1);
      data_valid = 1'b1; data_in = 8'h01;
      @(negedge clk); data_in = 8'h00;
      @(negedge clk); data_valid = 1'b0;
      @(negedge clk);
      chk("no_timeout_result", 32'(result), 32'h31);
      chk("no_timeout_rv", 32'(result_valid), 32'h1);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Byte-serial front end and result register for the 8-bit ALU. Accepts operand A, operand B and a 3-bit opcode as three successive bytes on a valid/ready input port, and drives the ALU datapath operand and `ALUControl` inputs from registers. It captures the mux output (`Resultado`) and presents it on a valid/ready output port with a zero flag. It is the stage directly upstream of the ALU output mux and consumes that mux's result.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: consecutive idle cycles allowed between bytes of one transaction. Range 1–255. Used only with `ALU_LOAD_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data_in` in 8: input byte (A, then B, then opcode).
- `data_valid` in 1: `data_in` valid.
- `data_ready` out 1: sequencer can accept a byte.
- `alu_a` out 8: registered operand A to the ALU datapath.
- `alu_b` out 8: registered operand B to the ALU datapath.
- `alu_control` out 3: registered opcode to the ALU output mux.
- `alu_resultado` in 8: combinational result from the ALU output mux.
- `result` out 8: captured result.
- `result_valid` out 1: `result` valid.
- `result_ready` in 1: consumer accepts the result.
- `zero` out 1: `result == 8'h00`, valid with `result_valid`.
- `timeout_err` out 1: one-cycle pulse when a partial load is aborted.

## Operation
- A byte is accepted on any rising edge where `data_valid && data_ready`.
- FSM states and transitions:
  - IDLE: an accepted byte goes to `alu_a`; next state LOAD_B.
  - LOAD_B: an accepted byte goes to `alu_b`; next state LOAD_OP.
  - LOAD_OP: accepted `data_in[2:0]` goes to `alu_control`; `data_in[7:3]` is ignored; next state EXEC.
  - EXEC: unconditionally captures `alu_resultado` into `result` and sets `zero`; next state RESULT.
  - RESULT: holds `result_valid = 1` until `result_ready`; on handshake returns to IDLE.
- `data_ready = 1` in IDLE, LOAD_B and LOAD_OP; 0 in EXEC and RESULT.
- Bytes presented while `data_ready = 0` are not consumed; the producer must hold them.
- `alu_a`, `alu_b` and `alu_control` keep their last values after the transaction; they are overwritten only by new accepted bytes.
- `result` and `zero` hold their values after the handshake until the next EXEC.
- Width rules: no arithmetic in this block; all data paths are 8 bits, opcode is 3 bits.
- In RESULT, `data_valid` with `result_ready` in the same cycle: the result handshake completes and the byte is not accepted. That byte is accepted on the next cycle in IDLE.
- `rst` in any state: next edge is IDLE. No pending result is delivered.

## Timing
- Reset values: `alu_a = 0`, `alu_b = 0`, `alu_control = 0`, `result = 0`, `zero = 0`, `result_valid = 0`, `timeout_err = 0`, `data_ready = 1` once in IDLE.
- Opcode accepted at edge N: EXEC occupies cycle N..N+1, `result` is captured at edge N+1, and `result_valid` is high from edge N+1. Latency is one cycle from opcode acceptance to result valid.
- The ALU datapath is purely combinational; it has one full cycle (EXEC) to settle from registered operands.
- Best-case throughput is one transaction per 5 cycles (3 loads, EXEC, RESULT with `result_ready` held high).

## Configuration
- `ALU_LOAD_TIMEOUT_EN` defined:
  - An 8-bit idle counter clears on every accepted byte and in IDLE, EXEC and RESULT.
  - It increments each LOAD_B/LOAD_OP cycle without acceptance.
  - When the counter reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE and `timeout_err` pulses high for exactly one cycle.
  - Byte acceptance on the expiry cycle wins: no abort occurs.
  - Operand registers are not cleared on abort.
  - RESULT never times out.
- `ALU_LOAD_TIMEOUT_EN` not defined: no counter is built, `timeout_err` is tied to 0 and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants `OP_SUMA = 3'b000`, `OP_RESTA = 3'b001`, `OP_AND = 3'b010`, `OP_OR = 3'b011`, `OP_SHL_A = 3'b100`, `OP_SHR_A = 3'b101`, `OP_SHL_B = 3'b110`, `OP_SHR_B = 3'b111`;
  - the FSM state encoding (IDLE, LOAD_B, LOAD_OP, EXEC, RESULT);
  - the 8-bit data width constant.
- One sub-module, `alu_load_timer`, holds the idle counter and expiry compare. It is instantiated only under `ALU_LOAD_TIMEOUT_EN`.

## Test plan
The bench connects the real ALU datapath (adder, subtractor, shifters, output mux).
- Bytes 0x05, 0x03, 0x00 back-to-back → `result_valid` 1 cycle after the third byte, `result = 0x08`, `zero = 0`; `alu_control = 3'b000`.
- Bytes 0x0F, 0xF0, 0x02 → `result = 0x00`, `zero = 1`. Bytes 0x0F, 0xF0, 0x03 → `result = 0xFF`, `zero = 0`.
- Hold `result_ready = 0` for 10 cycles after a 0x05, 0x03, 0x01 load → `result = 0x02` stable, `data_ready = 0` throughout; a `data_valid` byte 0xAA held meanwhile is accepted as the next A only after the handshake.
- Opcode byte 0xF9 → `alu_control = 3'b001` (upper bits ignored).
- Assert `rst` in LOAD_OP and again in RESULT → next cycle all outputs equal reset values, `data_ready = 1`, no `result_valid`.
- With `ALU_LOAD_TIMEOUT_EN` and `TIMEOUT_CYCLES = 4`: send A, then idle 4 cycles → `timeout_err` pulses once and the FSM is in IDLE. Repeat with B arriving on the 4th idle cycle → no abort.
